// File: rtl/pa_fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pa_fpu_pkg
// Brief    : Shared FPU writeback widths and result-source index constants.
// Revision : 1.0
// ============================================================================
package pa_fpu_pkg;

  localparam int FREG_W   = 5;
  localparam int FFLAG_W  = 5;

  localparam int SRC_FDSU = 0;
  localparam int SRC_EX2  = 1;
  localparam int SRC_EX3  = 2;
  localparam int SRC_EX4  = 3;

endpackage
`default_nettype wire

// File: rtl/pa_fpu_prio_arb.sv
`default_nettype none
// ============================================================================
// Module   : pa_fpu_prio_arb
// Brief    : Fixed-priority pick (highest index wins) with a force-index override.
// Revision : 1.0
// ============================================================================
module pa_fpu_prio_arb #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic             i_force_en,
  input  logic [IDX_W-1:0] i_force_idx,
  output logic [N-1:0]     o_grant_oh,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  localparam logic [N-1:0] C_ONE = N'(1);

  logic [IDX_W-1:0] w_idx;
  logic             w_any;

  always_comb begin
    w_idx = '0;
    w_any = |i_req;
    for (int i = 0; i < N; i++) begin
      if (i_req[i]) w_idx = IDX_W'(i);
    end
    if (i_force_en) begin
      w_idx = i_force_idx;
      w_any = 1'b1;
    end
  end

  assign o_idx      = w_idx;
  assign o_any      = w_any;
  assign o_grant_oh = w_any ? (C_ONE << w_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/pa_fpu_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : pa_fpu_wb_arb
// Brief    : N-source FPU result writeback arbiter with a one-entry registered
//            slot toward RTU and a starvation guard for the divide/sqrt source.
// Revision : 1.0
// ============================================================================
module pa_fpu_wb_arb
  import pa_fpu_pkg::*;
#(
  parameter int NSRC       = 4,
  parameter int FLEN       = 32,
  parameter int STARVE_MAX = 7
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  input  logic [NSRC-1:0]         src_req,
  input  logic [NSRC*FREG_W-1:0]  src_freg,
  input  logic [NSRC*FLEN-1:0]    src_data,
  input  logic [NSRC*FFLAG_W-1:0] src_fflags,
  output logic [NSRC-1:0]         src_grant,
  input  logic                    rtu_fpu_fgpr_wb_grant,
  output logic                    fpu_rtu_fgpr_wb_vld,
  output logic [FREG_W-1:0]       fpu_rtu_fgpr_wb_reg,
  output logic [FLEN-1:0]         fpu_rtu_fgpr_wb_data,
  output logic                    fpu_idu_fwd_vld,
  output logic [FREG_W-1:0]       fpu_idu_fwd_freg,
  output logic [FLEN-1:0]         fpu_idu_fwd_data,
  input  logic                    fpu_rtu_ex3_wb_fflags_vld,
  input  logic [FFLAG_W-1:0]      fpu_rtu_ex3_wb_fflags,
  input  logic                    rtu_fpu_ex3_wb_grant,
  output logic                    fpu_cp0_wb_fflags_updt,
  output logic [FFLAG_W-1:0]      fpu_cp0_wb_fflags
);

  localparam int               IDX_W        = $clog2(NSRC);
  localparam int               CNT_W        = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);

  logic                 r_slot_vld;
  logic [FREG_W-1:0]    r_slot_freg;
  logic [FLEN-1:0]      r_slot_data;
  logic [FFLAG_W-1:0]   r_slot_fflags;
  logic                 r_flt_updt;
  logic [FFLAG_W-1:0]   r_flt_fflags;
  logic [CNT_W-1:0]     r_starve_cnt;

  logic                 w_drain;
  logic                 w_slot_free;
  logic                 w_force;
  logic                 w_gate_en;
  logic                 w_load;
  logic                 w_int_updt;
  logic [NSRC-1:0]      w_pick_oh;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_any;
  logic [FREG_W-1:0]    w_win_freg;
  logic [FLEN-1:0]      w_win_data;
  logic [FFLAG_W-1:0]   w_win_fflags;

  assign w_drain     = r_slot_vld & rtu_fpu_fgpr_wb_grant;
  assign w_slot_free = ~r_slot_vld | w_drain;
  assign w_force     = (r_starve_cnt == C_STARVE_MAX) & src_req[SRC_FDSU] & w_slot_free;

  pa_fpu_prio_arb #(
    .N     (NSRC),
    .IDX_W (IDX_W)
  ) u_prio_arb (
    .i_req       (src_req),
    .i_force_en  (w_force),
    .i_force_idx (IDX_W'(SRC_FDSU)),
    .o_grant_oh  (w_pick_oh),
    .o_idx       (w_pick_idx),
    .o_any       (w_pick_any)
  );

  assign src_grant = w_slot_free ? w_pick_oh : '0;
  assign w_load    = w_slot_free & w_pick_any;

  // One-hot select keeps every part-select index constant.
  always_comb begin
    w_win_freg   = '0;
    w_win_data   = '0;
    w_win_fflags = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_pick_oh[i]) begin
        w_win_freg   = src_freg[i*FREG_W +: FREG_W];
        w_win_data   = src_data[i*FLEN +: FLEN];
        w_win_fflags = src_fflags[i*FFLAG_W +: FFLAG_W];
      end
    end
  end

  // Local clock-gate enable for the slot and float-fflags registers.
  assign w_gate_en = (|src_req) | r_slot_vld | r_flt_updt;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_slot_vld   <= 1'b0;
      r_flt_updt   <= 1'b0;
      r_flt_fflags <= '0;
    end else if (w_gate_en) begin
      if (w_load) begin
        r_slot_vld <= 1'b1;
      end else if (w_drain) begin
        r_slot_vld <= 1'b0;
      end
      r_flt_updt <= w_drain;
      if (w_drain) r_flt_fflags <= r_slot_fflags;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (w_load) begin
      r_slot_freg   <= w_win_freg;
      r_slot_data   <= w_win_data;
      r_slot_fflags <= w_win_fflags;
    end
  end

  // Kept outside the gated domain so a dropped source-0 request still clears it.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_starve_cnt <= '0;
    end else if (!src_req[SRC_FDSU] || src_grant[SRC_FDSU]) begin
      r_starve_cnt <= '0;
    end else if (w_load && (r_starve_cnt != C_STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  assign fpu_rtu_fgpr_wb_vld  = r_slot_vld;
  assign fpu_rtu_fgpr_wb_reg  = r_slot_freg;
  assign fpu_rtu_fgpr_wb_data = r_slot_data;
  assign fpu_idu_fwd_vld      = r_slot_vld;
  assign fpu_idu_fwd_freg     = r_slot_freg;
  assign fpu_idu_fwd_data     = r_slot_data;

  assign w_int_updt             = rtu_fpu_ex3_wb_grant & fpu_rtu_ex3_wb_fflags_vld;
  assign fpu_cp0_wb_fflags_updt = w_int_updt | r_flt_updt;
  assign fpu_cp0_wb_fflags      = ({FFLAG_W{w_int_updt}} & fpu_rtu_ex3_wb_fflags)
                                | ({FFLAG_W{r_flt_updt}} & r_flt_fflags);

endmodule
`default_nettype wire

// File: tb/tb_pa_fpu_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pa_fpu_wb_arb
// Brief    : Directed self-checking bench for pa_fpu_wb_arb (NSRC=4, FLEN=32).
// Revision : 1.0
// ============================================================================
module tb_pa_fpu_wb_arb;

  localparam int STARVE = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   src_req;
  logic [19:0]  src_freg;
  logic [127:0] src_data;
  logic [19:0]  src_fflags;
  logic [3:0]   src_grant;
  logic         rtu_grant;
  logic         wb_vld;
  logic [4:0]   wb_reg;
  logic [31:0]  wb_data;
  logic         fwd_vld;
  logic [4:0]   fwd_freg;
  logic [31:0]  fwd_data;
  logic         int_vld;
  logic [4:0]   int_flags;
  logic         int_grant;
  logic         updt;
  logic [4:0]   flags;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  pa_fpu_wb_arb #(.NSRC(4), .FLEN(32), .STARVE_MAX(STARVE)) dut (
    .forever_cpuclk            (clk),
    .cpurst_b                  (rst_n),
    .src_req                   (src_req),
    .src_freg                  (src_freg),
    .src_data                  (src_data),
    .src_fflags                (src_fflags),
    .src_grant                 (src_grant),
    .rtu_fpu_fgpr_wb_grant     (rtu_grant),
    .fpu_rtu_fgpr_wb_vld       (wb_vld),
    .fpu_rtu_fgpr_wb_reg       (wb_reg),
    .fpu_rtu_fgpr_wb_data      (wb_data),
    .fpu_idu_fwd_vld           (fwd_vld),
    .fpu_idu_fwd_freg          (fwd_freg),
    .fpu_idu_fwd_data          (fwd_data),
    .fpu_rtu_ex3_wb_fflags_vld (int_vld),
    .fpu_rtu_ex3_wb_fflags     (int_flags),
    .rtu_fpu_ex3_wb_grant      (int_grant),
    .fpu_cp0_wb_fflags_updt    (updt),
    .fpu_cp0_wb_fflags         (flags)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic set_src(input int i, input logic [4:0] f, input logic [31:0] d, input logic [4:0] fl);
    src_freg[i*5 +: 5]     = f;
    src_data[i*32 +: 32]   = d;
    src_fflags[i*5 +: 5]   = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: winner from the priority/starvation rules, slot as a held entry.
  logic        m_vld;
  logic [4:0]  m_freg;
  logic [31:0] m_data;
  logic [4:0]  m_flags;
  logic        m_flt;
  logic [4:0]  m_flt_flags;
  int          m_loss;
  int          m_w;

  function automatic int m_winner(input logic [3:0] req, input logic vld, input logic rg, input int loss);
    if (vld && !rg) return -1;
    if (req[0] && loss >= STARVE) return 0;
    for (int i = 3; i >= 0; i--) if (req[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] exp_grant(input int w);
    return (w >= 0) ? (4'b0001 << w) : 4'b0000;
  endfunction

  assign m_w = m_winner(src_req, m_vld, rtu_grant, m_loss);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld  <= 1'b0;
      m_flt  <= 1'b0;
      m_loss <= 0;
    end else begin
      if (m_w >= 0) begin
        m_vld   <= 1'b1;
        m_freg  <= src_freg[m_w*5 +: 5];
        m_data  <= src_data[m_w*32 +: 32];
        m_flags <= src_fflags[m_w*5 +: 5];
      end else if (m_vld && rtu_grant) begin
        m_vld <= 1'b0;
      end
      m_flt <= m_vld && rtu_grant;
      if (m_vld && rtu_grant) m_flt_flags <= m_flags;
      if (!src_req[0] || m_w == 0) m_loss <= 0;
      else if (m_w > 0 && m_loss < STARVE) m_loss <= m_loss + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("m_grant", src_grant, exp_grant(m_w));
      check("m_wb_vld", wb_vld, m_vld);
      check("m_fwd_vld", fwd_vld, m_vld);
      if (m_vld) begin
        check("m_wb_reg", wb_reg, m_freg);
        check("m_wb_data", wb_data, m_data);
        check("m_fwd_freg", fwd_freg, m_freg);
        check("m_fwd_data", fwd_data, m_data);
      end
      check("m_updt", updt, (int_grant && int_vld) || m_flt);
      check("m_flags", flags, ((int_grant && int_vld) ? int_flags : 5'b0) | (m_flt ? m_flt_flags : 5'b0));
    end
  end

  initial begin
    rst_n     = 1'b0;
    src_req   = '0;
    rtu_grant = 1'b0;
    int_vld   = 1'b0;
    int_grant = 1'b0;
    int_flags = '0;
    src_freg  = '0;
    src_data  = '0;
    src_fflags = '0;
    for (int i = 0; i < 4; i++) set_src(i, 5'(8 + i), 32'hD000_0000 + i, 5'(1 << i));
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    #1;
    check("rst_wb_vld", wb_vld, 0);
    check("rst_grant", src_grant, 0);
    check("rst_updt", updt, 0);
    check("rst_flags", flags, 0);
    tick();

    // Two requesters, RTU always ready.
    rtu_grant = 1'b1;
    src_req   = 4'b0110;
    #1 check("a_grant", src_grant, 4'b0100);
    tick();
    src_req = 4'b0000;
    #1;
    check("a_wb_vld", wb_vld, 1);
    check("a_wb_reg", wb_reg, 5'd10);
    check("a_wb_data", wb_data, 32'hD000_0002);
    check("a_fwd_data", fwd_data, 32'hD000_0002);
    tick();

    // Slot full and RTU stalled, then released: back-to-back refill.
    rtu_grant = 1'b0;
    src_req   = 4'b1000;
    tick();
    set_src(3, 5'd20, 32'hBEEF_0003, 5'b00100);
    #1 check("b_grant_stall", src_grant, 4'b0000);
    tick();
    check("b_grant_stall2", src_grant, 4'b0000);
    check("b_hold_data", wb_data, 32'hD000_0003);
    rtu_grant = 1'b1;
    #1 check("b_grant_rel", src_grant, 4'b1000);
    tick();
    check("b_refill_vld", wb_vld, 1);
    check("b_refill_data", wb_data, 32'hBEEF_0003);
    check("b_refill_reg", wb_reg, 5'd20);
    src_req = 4'b0000;
    tick();
    tick();

    // Source 0 competing continuously with source 3.
    src_req = 4'b1001;
    for (int k = 0; k < 8; k++) begin
      #1 check("s_grant", src_grant, (k < 7) ? 4'b1000 : 4'b0001);
      tick();
    end
    #1 check("s_after", src_grant, 4'b1000);
    tick();
    src_req = 4'b0000;
    tick();
    tick();

    // Float and integer fflags updates in consecutive cycles.
    set_src(1, 5'd11, 32'h1111_0001, 5'b00001);
    rtu_grant = 1'b0;
    src_req   = 4'b0010;
    tick();
    src_req   = 4'b0000;
    rtu_grant = 1'b1;
    int_vld   = 1'b1;
    int_grant = 1'b1;
    int_flags = 5'b10000;
    #1;
    check("f_n_updt", updt, 1);
    check("f_n_flags", flags, 5'b10000);
    tick();
    int_vld   = 1'b0;
    int_grant = 1'b0;
    #1;
    check("f_n1_updt", updt, 1);
    check("f_n1_flags", flags, 5'b00001);
    tick();

    // Reset with a full slot and a pending float update.
    src_req = 4'b0100;
    tick();
    tick();
    src_req   = 4'b0000;
    rtu_grant = 1'b0;
    #1;
    check("r_pre_vld", wb_vld, 1);
    check("r_pre_updt", updt, 1);
    rst_n = 1'b0;
    #1;
    check("r_wb_vld", wb_vld, 0);
    check("r_updt", updt, 0);
    check("r_flags", flags, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("r_post_vld", wb_vld, 0);
    check("r_post_updt", updt, 0);
    check("r_post_grant", src_grant, 0);
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pa_fpu_wb_arb.md
# pa_fpu_wb_arb

Parametrised FPU result writeback arbiter. It replaces the combinational four-source result bus with three changes: an N-source fixed-priority arbiter, a registered one-entry writeback slot with a valid/grant handshake toward RTU, and a starvation guard for the lowest-priority (iterative divide/sqrt) source. It sits between the FPU execution pipes and RTU/IDU. It drives the FGPR writeback, the IDU forwarding path and the fflags update to CP0.

## Interface
- NSRC, default 4: number of result sources; index 0 is lowest priority (FDSU), index NSRC-1 highest (oldest pipe stage); minimum 2.
- FLEN, default 32: result data width.
- STARVE_MAX, default 7: consecutive lost arbitrations by source 0 before it is forced to win; range 1..255.
- forever_cpuclk  in  1  clock.
- cpurst_b  in  1  asynchronous active-low reset.
- src_req  in  NSRC  per-source writeback request.
- src_freg  in  NSRC*5  per-source destination FGPR; source i at [5i+4:5i].
- src_data  in  NSRC*FLEN  per-source result.
- src_fflags  in  NSRC*5  per-source exception flags.
- src_grant  out  NSRC  one-hot; source i may retire its result this cycle.
- rtu_fpu_fgpr_wb_grant  in  1  RTU consumes the slot this cycle.
- fpu_rtu_fgpr_wb_vld / _reg / _data  out  1 / 5 / FLEN  slot contents.
- fpu_idu_fwd_vld / _freg / _data  out  1 / 5 / FLEN  same as the slot contents.
- fpu_rtu_ex3_wb_fflags_vld  in  1  integer-destination fflags pending.
- fpu_rtu_ex3_wb_fflags  in  5  integer-destination fflags.
- rtu_fpu_ex3_wb_grant  in  1  RTU retires the integer-destination op.
- fpu_cp0_wb_fflags_updt  out  1  fflags write strobe.
- fpu_cp0_wb_fflags  out  5  flags to OR into fcsr.

## Operation
- Slot state: slot_vld, slot_freg, slot_data, slot_fflags.
- drain = slot_vld && rtu_fpu_fgpr_wb_grant.
- slot_free = !slot_vld || drain.
- Arbitration, when no starvation override is active: the winner is the highest-index i with src_req[i]. src_grant[i] = winner && slot_free. If !slot_free, all grants are 0.
- Starvation counter starve_cnt, width clog2(STARVE_MAX+1):
  - Increments when src_req[0] && slot_free && another source wins.
  - Clears when src_grant[0], or when src_req[0] is low.
  - Saturates at STARVE_MAX.
  - When starve_cnt == STARVE_MAX && src_req[0] && slot_free, source 0 wins over all others, and the counter clears.
- Slot load: on any grant, load the winner's freg, data and fflags and set slot_vld = 1.
  - Load while draining: back-to-back transfer, slot_vld stays 1.
  - Drain with no grant: slot_vld clears.
- Float fflags:
  - On drain, register flt_updt = 1 and flt_fflags = slot_fflags.
  - Otherwise flt_updt = 0 next cycle.
- Integer fflags: int_updt = rtu_fpu_ex3_wb_grant && fpu_rtu_ex3_wb_fflags_vld, combinational, same cycle.
- fpu_cp0_wb_fflags_updt = int_updt || flt_updt.
- fpu_cp0_wb_fflags = masked OR of the two flag sources; both may be active in the same cycle.
- Slot data is not reset. Its value is don't-care while slot_vld = 0.

## Timing
- Reset values: slot_vld 0, all *_vld outputs 0, flt_updt 0, starve_cnt 0, fpu_cp0_wb_fflags 0.
- src_grant is combinational from src_req, slot_vld, rtu grant and starve_cnt. It never depends on src_data.
- Latency:
  - Grant to wb_vld: 1 cycle.
  - Drain to float fflags_updt: 1 cycle.
  - Throughput is 1 result per cycle while RTU grants continuously.
- rtu grant while slot_vld = 0 is ignored.
- Reset assertion mid-transfer discards the slot and any pending flt_updt immediately.

## Structure
- Shared package pa_fpu_pkg holds FREG_W = 5, FFLAG_W = 5, and the source index constants SRC_FDSU = 0, SRC_EX2 = 1, SRC_EX3 = 2, SRC_EX4 = 3.
- One sub-module, pa_fpu_prio_arb (parametrised fixed-priority pick with force-index input), instantiated once.
- Clock gating uses the existing gated_clk_cell on the fflags/slot registers, with local enable = any src_req || slot_vld || flt_updt.

## Test plan
- Reset, then idle: all outputs 0. src_req = 4'b0110 with RTU grant held 1 → src_grant = 4'b0100; next cycle wb_vld = 1 with source 2's reg/data.
- Slot full and RTU grant 0, src_req = 4'b1000 → src_grant = 0 and the slot holds. Raise RTU grant → same cycle src_grant = 4'b1000; slot refills, wb_vld stays 1.
- src_req[0] held with src_req[3] continuously and STARVE_MAX = 7 → src_grant[0] on the 8th slot_free cycle; the counter then returns to 0.
- Drain a slot carrying fflags 5'b00001 while the integer path retires with 5'b10000 in the same cycle → cycle N: updt = 1, flags 10000. Cycle N+1: updt = 1, flags 00001.
- Assert cpurst_b low with slot_vld = 1 and a pending flt_updt → wb_vld = 0 and updt = 0 immediately, and both stay 0 after release with no requests.
